// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front end for the single-cycle MIPS datapath.
// Holds the PC, fetches one instruction per step over a req/ready handshake,
// strobes it to the decoder for one cycle and commits the selected next PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_off,
  input  logic [31:0] jr_target,
  input  logic        jump_sel_n,
  input  logic        jal_sel_n,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] instr_count,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc;
  logic        take_jump;
  logic        take_jr;
  logic        jr_misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC select: jump/jal beats JR, JR beats a taken branch, else sequential.
  always_comb begin
    next_pc       = pc_plus4;
    take_jump     = !jump_sel_n || !jal_sel_n;
    take_jr       = 1'b0;
    jr_misaligned = 1'b0;
    if (take_jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (pc_sel == 2'b11) begin
      take_jr       = 1'b1;
      next_pc       = {jr_target[31:2], 2'b00};
      jr_misaligned = (jr_target[1:0] != 2'b00);
    end else if (pc_sel != 2'b00) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // FSM next state plus the datapath updates that happen on leaving REQ or EXEC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        pc_d    = next_pc;
        count_d = count_q + 32'd1;
        if (take_jr && jr_misaligned) begin
          misalign_d = 1'b1;
        end
        state_d = halt ? HALT : REQ;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset overrides halt and any pending fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      count_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == REQ);
  assign imem_addr    = pc_q;
  assign instr_valid  = (state_q == EXEC);
  assign halted       = (state_q == HALT);
  assign pc           = pc_q;
  assign instruction  = instr_q;
  assign instr_count  = count_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model updated by the stimulus
// tasks, a negedge compare process, and literal checks on key PC values.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_sel;
  logic [31:0] branch_off;
  logic [31:0] jr_target;
  logic        jump_sel_n;
  logic        jal_sel_n;
  logic        halt;
  logic        halted;
  logic [31:0] instr_count;
  logic        misalign_err;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .pc_sel(pc_sel), .branch_off(branch_off), .jr_target(jr_target),
    .jump_sel_n(jump_sel_n), .jal_sel_n(jal_sel_n), .halt(halt),
    .halted(halted), .instr_count(instr_count), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Model of what the outputs must show in the current cycle.
  logic [31:0] m_pc, m_instr, m_count;
  logic        m_mis, m_halted, m_req, m_valid;
  logic        check_en = 1'b0;
  logic [31:0] exec_p4;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Next PC straight from the selection rules.
  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] ins,
      input logic [1:0] sel, input logic [31:0] off, input logic [31:0] jr,
      input logic jn, input logic jaln, output logic mis);
    logic [31:0] p4;
    p4  = cur + 32'd4;
    mis = 1'b0;
    if (!jn || !jaln) return {p4[31:28], ins[25:0], 2'b00};
    if (sel == 2'b11) begin
      mis = (jr[1:0] != 2'b00);
      return {jr[31:2], 2'b00};
    end
    if (sel != 2'b00) return p4 + off;
    return p4;
  endfunction

  // Compare every output against the model each cycle, mid-period.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("imem_req",     {31'b0, imem_req},     {31'b0, m_req});
      checkOutput("imem_addr",    imem_addr,             m_pc);
      checkOutput("instr_valid",  {31'b0, instr_valid},  {31'b0, m_valid});
      checkOutput("pc",           pc,                    m_pc);
      checkOutput("pc_plus4",     pc_plus4,              m_pc + 32'd4);
      checkOutput("instruction",  instruction,           m_instr);
      checkOutput("halted",       {31'b0, halted},       {31'b0, m_halted});
      checkOutput("instr_count",  instr_count,           m_count);
      checkOutput("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Select inputs get random values whenever they must be ignored.
  task automatic scrambleSelects();
    pc_sel     = 2'($urandom_range(0, 3));
    branch_off = $urandom;
    jr_target  = $urandom;
    jump_sel_n = 1'($urandom_range(0, 1));
    jal_sel_n  = 1'($urandom_range(0, 1));
    halt       = 1'($urandom_range(0, 1));
  endtask

  // Reset for one edge, then an IDLE cycle with a stray ready pulse; returns in REQ.
  task automatic applyStimulus_reset();
    reset = 1'b1;
    scrambleSelects();
    step();
    m_pc = 32'h0; m_instr = 32'h0; m_count = 32'h0;
    m_mis = 1'b0; m_halted = 1'b0; m_req = 1'b0; m_valid = 1'b0;
    check_en   = 1'b1;
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = $urandom | 32'h1;
    step();
    m_req      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
  endtask

  // One fetch from REQ: waits, data, EXEC with the given selects; returns after EXEC.
  task automatic applyStimulus(input logic [31:0] word, input int waits,
      input logic [1:0] sel, input logic [31:0] off, input logic [31:0] jr,
      input logic jn, input logic jaln, input logic hlt);
    logic mis;
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      scrambleSelects();
      step();
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    scrambleSelects();
    step();
    m_instr = word; m_req = 1'b0; m_valid = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = $urandom;
    pc_sel = sel; branch_off = off; jr_target = jr;
    jump_sel_n = jn; jal_sel_n = jaln; halt = hlt;
    exec_p4 = pc_plus4;
    step();
    m_pc    = model_next_pc(m_pc, m_instr, sel, off, jr, jn, jaln, mis);
    m_mis   = m_mis | mis;
    m_count = m_count + 32'd1;
    m_valid = 1'b0;
    m_halted = hlt;
    m_req   = !hlt;
    imem_ready = 1'b0;
    scrambleSelects();
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
    pc_sel = 2'b00; branch_off = 32'h0; jr_target = 32'h0;
    jump_sel_n = 1'b1; jal_sel_n = 1'b1; halt = 1'b0;
    step();

    applyStimulus_reset();
    applyStimulus(32'h2008_0005, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("first_pc",    pc,          32'h4);
    checkOutput("first_count", instr_count, 32'h1);
    applyStimulus(32'h0000_0020, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0000_0021, 3, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("wait_pc", pc, 32'hC);
    applyStimulus(32'h0000_0022, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h1000_FFFE, 1, 2'b01, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("beq_pc", pc, 32'h0C);
    applyStimulus(32'h0000_0023, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h1400_0002, 0, 2'b10, 32'h8, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("bne_pc", pc, 32'h1C);
    applyStimulus(32'h0000_0008, 0, 2'b11, 32'h0, 32'h10, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0000_0024, 2, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("seq_pc", pc, 32'h14);
    applyStimulus(32'h0000_0008, 0, 2'b11, 32'h0, 32'h4000_0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h0C00_0010, 0, 2'b11, 32'h0, 32'h4000_0000, 1'b1, 1'b0, 1'b0);
    checkOutput("jal_pc",   pc,      32'h4000_0040);
    checkOutput("jal_link", exec_p4, 32'h4000_0004);
    applyStimulus(32'h0800_0020, 0, 2'b01, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("j_pc", pc, 32'h4000_0080);
    applyStimulus(32'h0C00_0030, 0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("jboth_pc", pc, 32'h4000_00C0);
    checkOutput("jboth_mis", {31'b0, misalign_err}, 32'h0);
    applyStimulus(32'h0000_0008, 0, 2'b11, 32'h0, 32'h0000_0102, 1'b1, 1'b1, 1'b0);
    checkOutput("jr_mis_pc", pc, 32'h100);
    checkOutput("jr_mis",    {31'b0, misalign_err}, 32'h1);
    applyStimulus(32'h0000_0025, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("mis_sticky", {31'b0, misalign_err}, 32'h1);
    applyStimulus(32'h1000_FF80, 0, 2'b01, 32'hFFFF_FE00, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("br_wrap_pc", pc, 32'hFFFF_FF08);

    // Abandon a pending fetch with reset, then restart.
    for (int i = 0; i < 2; i++) begin
      imem_ready = 1'b0;
      scrambleSelects();
      step();
    end
    applyStimulus_reset();
    checkOutput("rst_instr", instruction, 32'h0);
    checkOutput("rst_pc",    pc,          32'h0);
    applyStimulus(32'h2008_0005, 1, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("restart_pc", pc, 32'h4);

    // Halt, then confirm it stays quiet for 20 cycles.
    applyStimulus(32'h0000_000D, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("halt_pc", pc, 32'h8);
    checkOutput("halted",  {31'b0, halted}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      scrambleSelects();
      step();
    end
    applyStimulus_reset();
    checkOutput("halt_cleared", {31'b0, halted}, 32'h0);
    applyStimulus(32'h2008_0005, 0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch-side front end of the single-cycle MIPS datapath. Holds the program counter, fetches one instruction per step from instruction memory over a request/ready handshake, and presents it with a one-cycle valid strobe to the instruction decoder and branch/jump decode LUTs. In that same cycle it consumes their next-PC selects (branch/JR select, active-low jump/jal indices, branch offset, JR target) and commits the next PC.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high in REQ until imem_ready.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  memory has data this cycle; honoured only in REQ.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- instruction  out  32  registered instruction for the decoder; stable between fetches.
- instr_valid  out  1  one-cycle strobe: instruction executes and selects are sampled this cycle.
- pc  out  32  address of current instruction.
- pc_plus4  out  32  pc + 4 (mod 2^32); jal link value.
- pc_sel  in  2  00 sequential, 01 BEQ taken, 10 BNE taken, 11 JR.
- branch_off  in  32  sign-extended, <<2 branch offset.
- jr_target  in  32  register value for JR.
- jump_sel_n  in  1  0 = j.
- jal_sel_n  in  1  0 = jal.
- halt  in  1  stop after current instruction.
- halted  out  1  high in HALT.
- instr_count  out  32  retired-instruction counter, wraps.
- misalign_err  out  1  sticky; JR target had nonzero bits [1:0].

## Operation
- FSM states: IDLE, REQ, EXEC, HALT.
- IDLE: entered on reset; one cycle; -> REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ready=1: instruction <= imem_rdata, -> EXEC. Else stay.
- EXEC: instr_valid=1, imem_req=0. On exit: pc <= next_pc, instr_count += 1. -> HALT if halt=1, else REQ.
- HALT: no requests; holds all state; exits only via reset.
- next_pc priority (highest first):
  - jal_sel_n=0 or jump_sel_n=0: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - pc_sel=11: {jr_target[31:2], 2'b00}; set misalign_err if jr_target[1:0]!=0.
  - pc_sel=01 or 10: pc_plus4 + branch_off, 32-bit wrap.
  - pc_sel=00: pc_plus4.
- Both jump_sel_n and jal_sel_n low: same target as either one; no error.
- imem_ready outside REQ is ignored; imem_rdata not captured.
- All selects are sampled only in EXEC; values in other states have no effect.

## Timing
- Reset values: pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, pc_plus4=RESET_PC+4, halted=0, instr_count=0, misalign_err=0; state=IDLE.
- First imem_req: cycle after reset deasserts (IDLE then REQ).
- Zero-wait memory (imem_ready in first REQ cycle): 2 cycles per instruction (REQ, EXEC).
- N wait cycles add N cycles; imem_req and imem_addr stay constant throughout.
- instr_valid is high exactly one cycle per accepted imem_ready.
- pc, pc_plus4 change on the edge ending EXEC; imem_addr shows new pc in the next REQ cycle.
- Reset in any state, including REQ with a pending request, returns to IDLE next edge; a later imem_ready for the abandoned request is ignored.
- halt and reset same cycle: reset wins.
- instr_count wraps 32'hFFFF_FFFF -> 0 with no flag.

## Test plan
- Reset, zero-wait memory returning 32'h2008_0005 at 0: imem_req at cycle 1, instr_valid at cycle 2, pc=4 and instr_count=1 after EXEC.
- Memory with 3 wait cycles at pc=8: imem_req high 4 cycles with imem_addr=8, single instr_valid pulse, no capture of data presented before imem_ready.
- At pc=32'h10, pc_sel=01, branch_off=32'hFFFF_FFF8 -> next pc=32'h0C; pc_sel=10, branch_off=8 -> 32'h1C; pc_sel=00 -> 32'h14.
- At pc=32'h4000_0000, instruction=32'h0C00_0010 with jal_sel_n=0 and pc_sel=11 -> pc=32'h4000_0040, pc_plus4 was 32'h4000_0004; jr_target=32'h0000_0102 with pc_sel=11 alone -> pc=32'h100, misalign_err=1 and stays 1.
- Assert reset during REQ wait, then imem_ready pulse in IDLE -> instruction stays 0, no instr_valid, pc=RESET_PC, fetch restarts.
- halt=1 during EXEC -> pc updated, halted=1, imem_req remains 0 for 20 cycles; reset clears halted.
